// File: rtl/idli_nibble_io_m.sv
// idli_nibble_io_m
// Buffered nibble-stream <-> word FIFO bridge between the core datapath
// and the top-level din/dout pins.
//   RX: 4-bit din nibbles (valid/accept) are assembled LSB nibble first
//       into WORD_W-bit words and queued in a DEPTH-entry FIFO that the
//       core reads through o_io_rx_data / o_io_rx_vld / i_io_rx_rd.
//   TX: core words pushed through i_io_tx_data / i_io_tx_wr / o_io_tx_rdy
//       are queued and serialised LSB nibble first onto dout
//       (valid/accept).
//   i_io_flush synchronously empties both paths; i_io_rst_n is async,
//   active-low. Every ready/accept output is a function of registered
//   state only.
module idli_nibble_io_m #(
   parameter int WORD_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              i_io_gck,
   input  logic              i_io_rst_n,
   input  logic              i_io_flush,
   input  logic [3:0]        i_io_din,
   input  logic              i_io_din_vld,
   output logic              o_io_din_acp,
   output logic [3:0]        o_io_dout,
   output logic              o_io_dout_vld,
   input  logic              i_io_dout_acp,
   output logic [WORD_W-1:0] o_io_rx_data,
   output logic              o_io_rx_vld,
   input  logic              i_io_rx_rd,
   input  logic [WORD_W-1:0] i_io_tx_data,
   input  logic              i_io_tx_wr,
   output logic              o_io_tx_rdy
);

   localparam int NIBS = WORD_W / 4;
   localparam int IW   = $clog2(NIBS);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int PW   = $clog2(DEPTH);

   localparam logic [IW-1:0] LAST_NIB = IW'(NIBS - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // ------------------------------------------------------------------
   // RX path
   // ------------------------------------------------------------------
   // Only the lower NIBS-1 nibbles are held; the last nibble goes
   // straight from the pin into the FIFO entry.
   logic [WORD_W-5:0] rx_asm;
   logic [IW-1:0]     rx_idx;
   logic [WORD_W-1:0] rx_mem [DEPTH];
   logic [PW-1:0]     rx_wp;
   logic [PW-1:0]     rx_rp;
   logic [CW-1:0]     rx_cnt;
   logic              rx_take;
   logic              rx_push;
   logic              rx_pop;

   // Partial nibbles are always accepted; only the word-completing
   // nibble waits for FIFO space.
   assign o_io_din_acp = !(rx_idx == LAST_NIB && rx_cnt == FULL_CNT);
   assign rx_take      = i_io_din_vld && o_io_din_acp && !i_io_flush;
   assign rx_push      = rx_take && (rx_idx == LAST_NIB);
   assign rx_pop       = i_io_rx_rd && (rx_cnt != '0) && !i_io_flush;
   assign o_io_rx_vld  = (rx_cnt != '0);
   assign o_io_rx_data = o_io_rx_vld ? rx_mem[rx_rp] : '0;

   always_ff @(posedge i_io_gck or negedge i_io_rst_n) begin
      if (!i_io_rst_n) begin
         rx_asm <= '0;
         rx_idx <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else if (i_io_flush) begin
         rx_asm <= '0;
         rx_idx <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_take) begin
            for (int unsigned k = 0; k < NIBS - 1; k++) begin
               if (rx_idx == IW'(k)) rx_asm[4*k +: 4] <= i_io_din;
            end
            rx_idx <= (rx_idx == LAST_NIB) ? '0 : rx_idx + IW'(1);
         end
         if (rx_push) rx_wp <= rx_wp + PW'(1);
         if (rx_pop)  rx_rp <= rx_rp + PW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + CW'(1);
            2'b01:   rx_cnt <= rx_cnt - CW'(1);
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   always_ff @(posedge i_io_gck) begin
      if (rx_push) rx_mem[rx_wp] <= {i_io_din, rx_asm};
   end

   // ------------------------------------------------------------------
   // TX path
   // ------------------------------------------------------------------
   logic [WORD_W-1:0] tx_mem [DEPTH];
   logic [WORD_W-1:0] tx_head;
   logic [PW-1:0]     tx_wp;
   logic [PW-1:0]     tx_rp;
   logic [CW-1:0]     tx_cnt;
   logic [IW-1:0]     tx_idx;
   logic [3:0]        tx_nib;
   logic              tx_push;
   logic              tx_take;
   logic              tx_pop;

   // Readiness uses the pre-edge count, so a push to a full FIFO is
   // rejected even when the head pops in the same cycle.
   assign o_io_tx_rdy   = (tx_cnt != FULL_CNT);
   assign o_io_dout_vld = (tx_cnt != '0);
   assign tx_push       = i_io_tx_wr && o_io_tx_rdy && !i_io_flush;
   assign tx_take       = o_io_dout_vld && i_io_dout_acp && !i_io_flush;
   assign tx_pop        = tx_take && (tx_idx == LAST_NIB);
   assign tx_head       = tx_mem[tx_rp];

   always_comb begin
      tx_nib = '0;
      for (int unsigned k = 0; k < NIBS; k++) begin
         if (tx_idx == IW'(k)) tx_nib = tx_head[4*k +: 4];
      end
   end

   assign o_io_dout = o_io_dout_vld ? tx_nib : '0;

   always_ff @(posedge i_io_gck or negedge i_io_rst_n) begin
      if (!i_io_rst_n) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         tx_idx <= '0;
      end else if (i_io_flush) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         tx_idx <= '0;
      end else begin
         if (tx_take) tx_idx <= (tx_idx == LAST_NIB) ? '0 : tx_idx + IW'(1);
         if (tx_push) tx_wp <= tx_wp + PW'(1);
         if (tx_pop)  tx_rp <= tx_rp + PW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + CW'(1);
            2'b01:   tx_cnt <= tx_cnt - CW'(1);
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   always_ff @(posedge i_io_gck) begin
      if (tx_push) tx_mem[tx_wp] <= i_io_tx_data;
   end

endmodule

// File: tb/tb_idli_nibble_io_m.sv
// tb_idli_nibble_io_m
// Self-checking bench for idli_nibble_io_m (WORD_W=16, DEPTH=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_idli_nibble_io_m;

   localparam int W     = 16;
   localparam int NIBS  = W / 4;
   localparam int DEPTH = 4;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic [3:0]   din;
   logic         din_vld;
   logic         din_acp;
   logic [3:0]   dout;
   logic         dout_vld;
   logic         dout_acp;
   logic [W-1:0] rx_data;
   logic         rx_vld;
   logic         rx_rd;
   logic [W-1:0] tx_data;
   logic         tx_wr;
   logic         tx_rdy;

   int total;
   int bad;

   idli_nibble_io_m #(.WORD_W(W), .DEPTH(DEPTH)) dut (
      .i_io_gck      (clk),
      .i_io_rst_n    (rst_n),
      .i_io_flush    (flush),
      .i_io_din      (din),
      .i_io_din_vld  (din_vld),
      .o_io_din_acp  (din_acp),
      .o_io_dout     (dout),
      .o_io_dout_vld (dout_vld),
      .i_io_dout_acp (dout_acp),
      .o_io_rx_data  (rx_data),
      .o_io_rx_vld   (rx_vld),
      .i_io_rx_rd    (rx_rd),
      .i_io_tx_data  (tx_data),
      .i_io_tx_wr    (tx_wr),
      .o_io_tx_rdy   (tx_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      // inputs applied after the check
      logic [3:0]   din;
      logic         din_vld;
      logic         rx_rd;
      logic [W-1:0] tx_data;
      logic         tx_wr;
      logic         dout_acp;
      // outputs expected at the check
      logic         e_acp;
      logic         e_rxv;
      logic [W-1:0] e_rxd;
      logic         e_dv;
      logic [3:0]   e_dout;
      logic         e_rdy;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic idle_in();
      flush = 0; din = '0; din_vld = 0; rx_rd = 0; tx_data = '0; tx_wr = 0; dout_acp = 0;
   endtask

   // advance one clock; returns at the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic [3:0] d, input logic dv, input logic rd,
                               input logic [W-1:0] td, input logic tw, input logic da,
                               input logic ea, input logic erv, input logic [W-1:0] erd,
                               input logic edv, input logic [3:0] edo, input logic erdy);
      vec_t v;
      v.din = d; v.din_vld = dv; v.rx_rd = rd; v.tx_data = td; v.tx_wr = tw; v.dout_acp = da;
      v.e_acp = ea; v.e_rxv = erv; v.e_rxd = erd; v.e_dv = edv; v.e_dout = edo; v.e_rdy = erdy;
      return v;
   endfunction

   // reference model state: queues of whole words plus nibble positions
   logic [W-1:0] m_rxq[$];
   logic [W-1:0] m_txq[$];
   int unsigned  m_rxk;
   logic [W-1:0] m_part;
   int unsigned  m_txk;

   logic [W-1:0] rxw[5];
   logic [W-1:0] txw[5];
   logic [W-1:0] tmp;

   initial begin
      total = 0;
      bad   = 0;
      idle_in();
      rst_n = 0;

      // ---------------- reset state ----------------
      #3;
      chk("rst_acp", din_acp, 1);
      chk("rst_rxv", rx_vld, 0);
      chk("rst_rxd", rx_data, 0);
      chk("rst_dv", dout_vld, 0);
      chk("rst_dout", dout, 0);
      chk("rst_rdy", tx_rdy, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // ---------------- table: RX single word, TX back-to-back ----------------
      vecs[0]  = mk(4'h4, 1, 0, '0,       0, 0,  1, 0, '0,       0, 4'h0, 1);
      vecs[1]  = mk(4'h3, 1, 0, '0,       0, 0,  1, 0, '0,       0, 4'h0, 1);
      vecs[2]  = mk(4'h2, 1, 0, '0,       0, 0,  1, 0, '0,       0, 4'h0, 1);
      vecs[3]  = mk(4'h1, 1, 0, '0,       0, 0,  1, 0, '0,       0, 4'h0, 1);
      vecs[4]  = mk(4'h0, 0, 1, '0,       0, 0,  1, 1, 16'h1234, 0, 4'h0, 1);
      vecs[5]  = mk(4'h0, 0, 0, 16'hABCD, 1, 0,  1, 0, '0,       0, 4'h0, 1);
      vecs[6]  = mk(4'h0, 0, 0, 16'h1234, 1, 1,  1, 0, '0,       1, 4'hD, 1);
      vecs[7]  = mk(4'h0, 0, 0, '0,       0, 1,  1, 0, '0,       1, 4'hC, 1);
      vecs[8]  = mk(4'h0, 0, 0, '0,       0, 1,  1, 0, '0,       1, 4'hB, 1);
      vecs[9]  = mk(4'h0, 0, 0, '0,       0, 1,  1, 0, '0,       1, 4'hA, 1);
      vecs[10] = mk(4'h0, 0, 0, '0,       0, 1,  1, 0, '0,       1, 4'h4, 1);
      vecs[11] = mk(4'h0, 0, 0, '0,       0, 1,  1, 0, '0,       1, 4'h3, 1);
      vecs[12] = mk(4'h0, 0, 0, '0,       0, 1,  1, 0, '0,       1, 4'h2, 1);
      vecs[13] = mk(4'h0, 0, 0, '0,       0, 1,  1, 0, '0,       1, 4'h1, 1);
      vecs[14] = mk(4'h0, 0, 0, '0,       0, 0,  1, 0, '0,       0, 4'h0, 1);
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("vec%0d", i),
             {8'h0, din_acp, rx_vld, rx_data, dout_vld, dout, tx_rdy},
             {8'h0, vecs[i].e_acp, vecs[i].e_rxv, vecs[i].e_rxd, vecs[i].e_dv,
              vecs[i].e_dout, vecs[i].e_rdy});
         din = vecs[i].din; din_vld = vecs[i].din_vld; rx_rd = vecs[i].rx_rd;
         tx_data = vecs[i].tx_data; tx_wr = vecs[i].tx_wr; dout_acp = vecs[i].dout_acp;
         tick();
      end
      idle_in();

      // ---------------- TX backpressure ----------------
      tx_data = 16'h00F5; tx_wr = 1;
      tick();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         chk("bp_dout", dout, 4'h5);
         chk("bp_vld", dout_vld, 1);
         dout_acp = (i == 3);
         tick();
      end
      chk("bp_n1", dout, 4'hF); tick();
      chk("bp_n2", dout, 4'h0); tick();
      chk("bp_n3", dout, 4'h0); chk("bp_n3v", dout_vld, 1); tick();
      chk("bp_end", dout_vld, 0);
      idle_in();

      // ---------------- TX full ----------------
      txw = '{16'h1A2B, 16'h3C4D, 16'h5E6F, 16'h7081, 16'h9999};
      for (int i = 0; i < 5; i++) begin
         chk("txf_rdy", tx_rdy, (i < 4) ? 1 : 0);
         tx_data = txw[i]; tx_wr = 1;
         tick();
      end
      tx_wr = 0;
      chk("txf_rdy_full", tx_rdy, 0);
      dout_acp = 1;
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < NIBS; k++) begin
            tmp = txw[w] >> (4 * k);
            chk($sformatf("txf_w%0d_n%0d", w, k), dout, tmp[3:0]);
            tick();
         end
      end
      chk("txf_drop", dout_vld, 0);
      idle_in();

      // ---------------- RX full ----------------
      rxw = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hC0DE, 16'h5A5A};
      din_vld = 1;
      for (int w = 0; w < 5; w++) begin
         for (int k = 0; k < NIBS; k++) begin
            if (!(w == 4 && k == 3)) begin
               tmp = rxw[w] >> (4 * k);
               din = tmp[3:0];
               chk("rxf_acp", din_acp, 1);
               tick();
            end
         end
      end
      tmp = rxw[4] >> 12;
      din = tmp[3:0];
      chk("rxf_acp_low", din_acp, 0);
      tick();
      chk("rxf_acp_hold", din_acp, 0);
      chk("rxf_head", rx_data, rxw[0]);
      rx_rd = 1;
      chk("rxf_acp_pop", din_acp, 0);
      tick();
      rx_rd = 0;
      chk("rxf_acp_back", din_acp, 1);
      chk("rxf_head2", rx_data, rxw[1]);
      tick();
      din_vld = 0;
      for (int w = 1; w < 5; w++) begin
         chk($sformatf("rxf_pop%0d", w), rx_data, rxw[w]);
         rx_rd = 1;
         tick();
      end
      idle_in();
      chk("rxf_empty", rx_vld, 0);

      // ---------------- flush mid-word ----------------
      tx_data = 16'h4321; tx_wr = 1;
      tick();
      tx_wr = 0;
      din_vld = 1; din = 4'hE; dout_acp = 1;
      tick();
      chk("fl_dout_n1", dout, 4'h2);
      din = 4'hD; dout_acp = 0;
      tick();
      flush = 1; tx_wr = 1; tx_data = 16'hFFFF; din = 4'h7; din_vld = 1; dout_acp = 1; rx_rd = 1;
      tick();
      idle_in();
      chk("fl_rxv", rx_vld, 0);
      chk("fl_dv", dout_vld, 0);
      chk("fl_rdy", tx_rdy, 1);
      chk("fl_acp", din_acp, 1);
      chk("fl_dout", dout, 0);
      din_vld = 1;
      for (int k = 0; k < NIBS; k++) begin
         din = 4'(8 + k);
         tick();
      end
      idle_in();
      chk("fl_fresh_v", rx_vld, 1);
      chk("fl_fresh_d", rx_data, 16'hBA98);
      chk("fl_tx_idle", dout_vld, 0);
      rx_rd = 1;
      tick();
      idle_in();

      // ---------------- async reset mid-serialisation ----------------
      din_vld = 1; din = 4'h9;
      tx_data = 16'h00A7; tx_wr = 1;
      tick();
      idle_in();
      dout_acp = 1;
      tick();
      chk("ar_pre", dout, 4'hA);
      #2 rst_n = 0;
      #1;
      chk("ar_dv", dout_vld, 0);
      chk("ar_dout", dout, 0);
      chk("ar_rdy", tx_rdy, 1);
      chk("ar_rxv", rx_vld, 0);
      chk("ar_acp", din_acp, 1);
      @(negedge clk);
      rst_n = 1;
      idle_in();
      chk("ar_quiet", dout_vld, 0);
      tx_data = 16'h0001; tx_wr = 1;
      tick();
      tx_wr = 0; dout_acp = 1;
      for (int k = 0; k < NIBS; k++) begin
         chk($sformatf("ar_n%0d", k), dout, (k == 0) ? 4'h1 : 4'h0);
         tick();
      end
      chk("ar_end", dout_vld, 0);
      idle_in();

      // ---------------- randomized vs. queue model ----------------
      flush = 1;
      tick();
      flush = 0;
      m_rxq.delete(); m_txq.delete();
      m_rxk = 0; m_part = '0; m_txk = 0;
      for (int c = 0; c < 3000; c++) begin
         logic         e_acp, e_rxv, e_dv, e_rdy;
         logic [W-1:0] e_rxd, hsh;
         logic [3:0]   e_do;
         logic         do_txpush;
         e_acp = !(m_rxk == NIBS - 1 && m_rxq.size() == DEPTH);
         e_rxv = (m_rxq.size() != 0);
         e_rxd = e_rxv ? m_rxq[0] : '0;
         e_rdy = (m_txq.size() < DEPTH);
         e_dv  = (m_txq.size() != 0);
         hsh   = e_dv ? (m_txq[0] >> (4 * m_txk)) : '0;
         e_do  = hsh[3:0];
         chk("rnd_acp", din_acp, e_acp);
         chk("rnd_rxv", rx_vld, e_rxv);
         chk("rnd_rxd", rx_data, e_rxd);
         chk("rnd_rdy", tx_rdy, e_rdy);
         chk("rnd_dv", dout_vld, e_dv);
         chk("rnd_dout", dout, e_do);

         // phases alternate bias so both FIFOs fill and drain
         din      = 4'($urandom);
         din_vld  = ($urandom_range(0, 3) != 0);
         rx_rd    = ($urandom_range(0, 7) < ((c / 200) % 2 == 0 ? 2 : 6));
         tx_data  = 16'($urandom);
         tx_wr    = ($urandom_range(0, 3) != 0);
         dout_acp = ($urandom_range(0, 7) < ((c / 200) % 2 == 0 ? 2 : 7));
         flush    = ($urandom_range(0, 127) == 0);

         if (flush) begin
            m_rxq.delete(); m_txq.delete();
            m_rxk = 0; m_part = '0; m_txk = 0;
         end else begin
            do_txpush = tx_wr && e_rdy;
            if (rx_rd && e_rxv) void'(m_rxq.pop_front());
            if (din_vld && e_acp) begin
               m_part = m_part | (W'(din) << (4 * m_rxk));
               if (m_rxk == NIBS - 1) begin
                  m_rxq.push_back(m_part);
                  m_part = '0;
                  m_rxk = 0;
               end else begin
                  m_rxk++;
               end
            end
            if (e_dv && dout_acp) begin
               m_txk++;
               if (m_txk == NIBS) begin
                  void'(m_txq.pop_front());
                  m_txk = 0;
               end
            end
            if (do_txpush) m_txq.push_back(tx_data);
         end
         tick();
      end
      idle_in();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
